// File: rtl/pe2ddr_pkg.sv
// Shared parameters and types for the accum-buffer to DDR write-back path.
package pe2ddr_pkg;
  localparam int PE_NUM     = 32;
  localparam int BUF_DEPTH  = 256;
  localparam int DATA_W     = 16;
  localparam int BATCH      = 2;
  localparam int DDR_W      = 64;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;
  localparam int PIX_W      = DATA_W * BATCH;
  localparam int PACK_R     = DDR_W / PIX_W;
  localparam int ROW_W      = $clog2(BUF_DEPTH);
  localparam int PE_W       = $clog2(PE_NUM);
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam int PACK_CW    = $clog2(PACK_R + 1);

  typedef logic [PIX_W-1:0] pix_t;
  typedef enum logic [2:0] {IDLE, SEEK, ADDR, DATA, DRAIN} pe2ddr_state_e;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] step;
    logic [ROW_W-1:0]      pix;
    logic [PE_NUM-1:0]     mask;
  } pe2ddr_cfg_t;
endpackage

// File: rtl/pe2ddr_fifo.sv
// Small show-ahead FIFO between the buffer read port and the beat packer.
module pe2ddr_fifo
  import pe2ddr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  pix_t             wr_data,
  input  logic             rd_en,
  output pix_t             rd_data,
  output logic [FIFO_AW:0] count
);
  pix_t mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  assign rd_data = mem[rptr];
endmodule

// File: rtl/pe2ddr.sv
// Drains selected PE accum buffers to DDR: one address burst per PE, rows packed PACK_R per beat.
module pe2ddr
  import pe2ddr_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  input  logic [DDR_ADDR_W-1:0]     conf_st_addr,
  input  logic [DDR_ADDR_W-1:0]     conf_step,
  input  logic [ROW_W-1:0]          conf_pix_num,
  input  logic [PE_NUM-1:0]         conf_mask,
  output logic [ROW_W-1:0]          abuf_rd_addr,
  output logic [PE_NUM-1:0]         abuf_rd_en,
  input  logic [PE_NUM*PIX_W-1:0]   abuf_rd_data,
  output logic [DDR_ADDR_W-1:0]     ddr_addr,
  output logic [BURST_W-1:0]        ddr_size,
  output logic                      ddr_addr_valid,
  input  logic                      ddr_addr_ready,
  output logic [DDR_W-1:0]          ddr_data,
  output logic                      ddr_valid,
  input  logic                      ddr_ready,
  output logic                      ddr_last
);
  pe2ddr_state_e state, state_nxt;
  pe2ddr_cfg_t   cfg;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [PE_W:0]         pe_ptr;
  logic [PE_W-1:0]       pe_sel, seek_pe, rd_pe;
  logic [PE_NUM-1:0]     cand;
  logic                  seek_hit;
  logic [ROW_W-1:0]      row;
  logic                  rd_vld, rd_issue, rd_last;
  logic [FIFO_AW+1:0]    occ;
  pix_t                  fifo_dout;
  logic [FIFO_AW:0]      fifo_cnt;
  logic                  fifo_pop, beat_acc, drained, done_q;
  logic [PACK_CW-1:0]    pack_cnt;
  logic [BURST_W-1:0]    beat_cnt, burst_len;

  // Lowest set mask bit at or above pe_ptr; a shift by PE_NUM clears everything.
  always_comb begin
    cand    = cfg.mask & ({PE_NUM{1'b1}} << pe_ptr);
    seek_pe = '0;
    for (int i = PE_NUM - 1; i >= 0; i--)
      if (cand[i]) seek_pe = PE_W'(i);
  end
  assign seek_hit  = |cand;
  assign burst_len = BURST_W'(cfg.pix / ROW_W'(PACK_R));

  // In-flight read counts against FIFO space so a late write can never overflow it.
  assign occ      = {1'b0, fifo_cnt} + {{(FIFO_AW+1){1'b0}}, rd_vld};
  assign rd_issue = (state == DATA) && (occ < (FIFO_AW+2)'(FIFO_DEPTH));
  assign rd_last  = rd_issue && (row == cfg.pix - 1'b1);

  assign ddr_valid = (pack_cnt == PACK_CW'(PACK_R));
  assign beat_acc  = ddr_valid && ddr_ready;
  assign fifo_pop  = (fifo_cnt != '0) && (!ddr_valid || beat_acc);
  assign ddr_last  = ddr_valid && (beat_cnt == burst_len - 1'b1);
  assign drained   = (fifo_cnt == '0) && !rd_vld && (pack_cnt == '0);
  assign done      = done_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SEEK;
      SEEK:  state_nxt = (!seek_hit || cfg.pix == '0) ? DRAIN : ADDR;
      ADDR:  if (ddr_addr_ready) state_nxt = DATA;
      DATA:  if (rd_last) state_nxt = SEEK;
      DRAIN: if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ddr_addr_valid = 1'b0;
    ddr_addr       = '0;
    ddr_size       = '0;
    abuf_rd_en     = '0;
    abuf_rd_addr   = '0;
    if (state == ADDR) begin
      ddr_addr_valid = 1'b1;
      ddr_addr       = addr_q;
      ddr_size       = burst_len;
    end
    if (rd_issue) begin
      abuf_rd_en[pe_sel] = 1'b1;
      abuf_rd_addr       = row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg    <= '0;
      addr_q <= '0;
      pe_ptr <= '0;
      pe_sel <= '0;
      rd_pe  <= '0;
      row    <= '0;
      rd_vld <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      done_q <= (state == DRAIN) && drained;
      if (rd_issue) rd_pe <= pe_sel;
      case (state)
        IDLE: if (start) begin
          cfg    <= '{step: conf_step, pix: conf_pix_num, mask: conf_mask};
          addr_q <= conf_st_addr;
          pe_ptr <= '0;
        end
        SEEK: if (seek_hit) pe_sel <= seek_pe;
        ADDR: if (ddr_addr_ready) begin
          addr_q <= addr_q + cfg.step;
          row    <= '0;
        end
        DATA: if (rd_issue) begin
          row <= row + 1'b1;
          if (rd_last) pe_ptr <= {1'b0, pe_sel} + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pack register refills in the same cycle a beat is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ddr_data <= '0;
      pack_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_pop) begin
        if (beat_acc) begin
          ddr_data[PIX_W-1:0] <= fifo_dout;
          pack_cnt            <= PACK_CW'(1);
        end else begin
          ddr_data[pack_cnt*PIX_W +: PIX_W] <= fifo_dout;
          pack_cnt                          <= pack_cnt + 1'b1;
        end
      end else if (beat_acc) begin
        pack_cnt <= '0;
      end
      if (beat_acc) beat_cnt <= ddr_last ? '0 : beat_cnt + 1'b1;
    end
  end

  pe2ddr_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (rd_vld),
    .wr_data (abuf_rd_data[rd_pe*PIX_W +: PIX_W]),
    .rd_en   (fifo_pop),
    .rd_data (fifo_dout),
    .count   (fifo_cnt)
  );
endmodule

// File: tb/tb_pe2ddr.sv
// Directed bench for pe2ddr with a queue scoreboard for address bursts and data beats.
module tb_pe2ddr;
  import pe2ddr_pkg::*;

  typedef struct { logic [31:0] addr; logic [7:0] size; } addr_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  logic                    clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic                    done, busy;
  logic [DDR_ADDR_W-1:0]   conf_st_addr = '0, conf_step = '0;
  logic [ROW_W-1:0]        conf_pix_num = '0;
  logic [PE_NUM-1:0]       conf_mask = '0;
  logic [ROW_W-1:0]        abuf_rd_addr;
  logic [PE_NUM-1:0]       abuf_rd_en;
  logic [PE_NUM*PIX_W-1:0] abuf_rd_data = '0;
  logic [DDR_ADDR_W-1:0]   ddr_addr;
  logic [BURST_W-1:0]      ddr_size;
  logic                    ddr_addr_valid, ddr_addr_ready = 1'b1;
  logic [DDR_W-1:0]        ddr_data;
  logic                    ddr_valid, ddr_ready = 1'b1, ddr_last;

  int    errors = 0, checks = 0;
  int    rows_rd = 0, beats = 0, max_outst = 0, cyc = 0;
  logic  slow_ready = 1'b0, any_av = 1'b0, any_dv = 1'b0;
  addr_t exp_addr[$];
  beat_t exp_beat[$];
  addr_t ea;
  beat_t eb;

  pe2ddr dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .conf_st_addr(conf_st_addr), .conf_step(conf_step),
    .conf_pix_num(conf_pix_num), .conf_mask(conf_mask),
    .abuf_rd_addr(abuf_rd_addr), .abuf_rd_en(abuf_rd_en), .abuf_rd_data(abuf_rd_data),
    .ddr_addr(ddr_addr), .ddr_size(ddr_size), .ddr_addr_valid(ddr_addr_valid),
    .ddr_addr_ready(ddr_addr_ready), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
    .ddr_ready(ddr_ready), .ddr_last(ddr_last)
  );

  always #5 clk = ~clk;

  function automatic pix_t rowval(input int pe, input int r);
    return pix_t'(32'hC000_0000 | (pe << 16) | r);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer model: enabled PE returns its row one cycle later; other slices carry noise.
  always @(posedge clk) begin
    logic [PE_NUM*PIX_W-1:0] v;
    for (int p = 0; p < PE_NUM; p++)
      v[p*PIX_W +: PIX_W] = abuf_rd_en[p] ? rowval(p, int'(abuf_rd_addr)) : pix_t'($urandom);
    abuf_rd_data <= v;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    ddr_ready = slow_ready ? (cyc % 3 == 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (ddr_addr_valid) any_av = 1'b1;
      if (ddr_valid) any_dv = 1'b1;
      if (ddr_addr_valid && ddr_addr_ready) begin
        if (exp_addr.size() == 0) chk("addr_unexpected", 64'(exp_addr.size()), 64'd1);
        else begin
          ea = exp_addr.pop_front();
          chk("ddr_addr", 64'(ddr_addr), 64'(ea.addr));
          chk("ddr_size", 64'(ddr_size), 64'(ea.size));
        end
      end
      if (ddr_valid && ddr_ready) begin
        beats++;
        if (exp_beat.size() == 0) chk("beat_unexpected", 64'(exp_beat.size()), 64'd1);
        else begin
          eb = exp_beat.pop_front();
          chk("ddr_data", ddr_data, eb.data);
          chk("ddr_last", 64'(ddr_last), 64'(eb.last));
        end
      end
      if (abuf_rd_en != '0) begin
        rows_rd++;
        chk("rd_en_onehot", 64'($onehot(abuf_rd_en)), 64'd1);
      end
      if (rows_rd - 2 * beats > max_outst) max_outst = rows_rd - 2 * beats;
    end
  end

  task automatic push_job(input logic [31:0] st, input logic [31:0] step,
                          input logic [7:0] pix, input logic [31:0] mask);
    logic [31:0] a;
    a = st;
    for (int p = 0; p < PE_NUM; p++) begin
      if (mask[p]) begin
        exp_addr.push_back('{addr: a, size: pix / 2});
        for (int b = 0; b < pix / 2; b++)
          exp_beat.push_back('{data: {rowval(p, 2*b+1), rowval(p, 2*b)}, last: (b == pix/2 - 1)});
        a = a + step;
      end
    end
    conf_st_addr = st; conf_step = step; conf_pix_num = pix; conf_mask = mask;
    rows_rd = 0; beats = 0; max_outst = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    conf_st_addr = $urandom; conf_step = $urandom;
    conf_pix_num = ROW_W'($urandom); conf_mask = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
    chk("beat_queue_empty", 64'(exp_beat.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr_valid", 64'(ddr_addr_valid), 64'd0);
    chk("rst_ddr_valid", 64'(ddr_valid), 64'd0);
    chk("rst_rd_en", 64'(abuf_rd_en), 64'd0);
    rst = 1'b1;

    // single PE, 4 beats
    push_job(32'h1000, 32'h100, 8'd8, 32'h1);
    pulse_start();
    wait_done(500);

    // PE 0, 2, 31 in order; a second start while busy is ignored
    push_job(32'h1000, 32'h100, 8'd4, 32'h8000_0005);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("busy_mid_job", 64'(busy), 64'd1);
    pulse_start();
    wait_done(500);

    // backpressure on data, address wraps past 2^32
    slow_ready = 1'b1;
    push_job(32'hFFFF_FF80, 32'h100, 8'd8, 32'h3);
    pulse_start();
    wait_done(2000);
    chk("max_outstanding_rows", 64'(max_outst), 64'd6);
    slow_ready = 1'b0;

    // empty mask: SEEK, DRAIN, done
    push_job(32'h1000, 32'h100, 8'd8, 32'h0);
    any_av = 1'b0; any_dv = 1'b0;
    pulse_start();
    chk("mask0_busy", 64'(busy), 64'd1);
    chk("mask0_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    chk("mask0_done_c2", 64'(done), 64'd0);
    @(negedge clk);
    chk("mask0_done_c3", 64'(done), 64'd1);
    @(negedge clk);
    chk("mask0_done_c4", 64'(done), 64'd0);
    chk("mask0_no_addr", 64'(any_av), 64'd0);
    chk("mask0_no_data", 64'(any_dv), 64'd0);

    // reset while reading
    push_job(32'h2000, 32'h100, 8'd8, 32'h1);
    pulse_start();
    n = 0;
    while (abuf_rd_en == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_data", 64'(abuf_rd_en != '0), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_rd_en", 64'(abuf_rd_en), 64'd0);
    chk("abort_rd_addr", 64'(abuf_rd_addr), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_addr_valid", 64'(ddr_addr_valid), 64'd0);
    chk("abort_ddr_valid", 64'(ddr_valid), 64'd0);
    chk("abort_ddr_data", ddr_data, 64'd0);
    chk("abort_ddr_last", 64'(ddr_last), 64'd0);
    exp_addr.delete();
    exp_beat.delete();
    @(negedge clk) rst = 1'b1;
    push_job(32'h3000, 32'h100, 8'd8, 32'h10);
    pulse_start();
    wait_done(500);

    // longest even row count, address channel stalled first
    push_job(32'h4000, 32'h40, 8'd254, 32'h2);
    ddr_addr_ready = 1'b0;
    pulse_start();
    repeat (10) begin
      @(negedge clk);
      chk("no_read_before_addr", 64'(abuf_rd_en), 64'd0);
    end
    chk("addr_valid_held", 64'(ddr_addr_valid), 64'd1);
    ddr_addr_ready = 1'b1;
    wait_done(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
